// File: rtl/bus_arbiter_2m.sv
// Two-master Wishbone-style arbiter sharing one SRAM slave between the data
// port (m0) and the instruction-fetch port (m1), with a no-response watchdog.
module bus_arbiter_2m #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_bus,
  input  logic              rst_bus,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m0_we_i,
  input  logic              m1_we_i,
  input  logic              m0_cyc_i,
  input  logic              m1_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m1_stb_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m0_ack_o,
  output logic              m1_ack_o,
  output logic              m0_err_o,
  output logic              m1_err_o,
  output logic              m0_rty_o,
  output logic              m1_rty_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] wd_cnt;
  logic             tmo_q;
  logic             own0;
  logic             own1;
  logic             owner_cyc;
  logic             s_resp;

  assign own0      = (state == GRANT0);
  assign own1      = (state == GRANT1);
  assign owner_cyc = own0 ? m0_cyc_i : m1_cyc_i;
  assign s_resp    = s_ack_i | s_err_i | s_rty_i;

  // While the watchdog pulse is out, the cycle is torn down on the slave side.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i & ~tmo_q;
      s_stb_o = m0_cyc_i & m0_stb_i & ~tmo_q;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i & ~tmo_q;
      s_stb_o = m1_cyc_i & m1_stb_i & ~tmo_q;
    end
  end

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = own0 & s_ack_i & ~tmo_q;
  assign m1_ack_o  = own1 & s_ack_i & ~tmo_q;
  assign m0_err_o  = own0 & (s_err_i | tmo_q);
  assign m1_err_o  = own1 & (s_err_i | tmo_q);
  assign m0_rty_o  = own0 & s_rty_i & ~tmo_q;
  assign m1_rty_o  = own1 & s_rty_i & ~tmo_q;
  assign grant_o   = {own1, own0};
  assign timeout_o = tmo_q;

  // last_grant only moves on contended grants, so lone requests don't skew the alternation.
  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wd_cnt     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            if (last_grant) begin
              state      <= GRANT0;
              last_grant <= 1'b0;
            end else begin
              state      <= GRANT1;
              last_grant <= 1'b1;
            end
          end else if (m0_cyc_i) begin
            state <= GRANT0;
          end else if (m1_cyc_i) begin
            state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (tmo_q || !owner_cyc) begin
            state  <= IDLE;
            wd_cnt <= '0;
          end else if (TIMEOUT > 0) begin
            if (s_resp) begin
              wd_cnt <= '0;
            end else if (s_stb_o) begin
              if (wd_cnt == TMO_VAL) tmo_q <= 1'b1;
              else                   wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master, one-slave Wishbone-style arbiter that shares the SRAM bus slave between the data port (m0) and the instruction-fetch port (m1).
- It grants the slave to one master for a whole bus cycle (cyc held), muxes request signals to the slave and routes responses back to the owner only.
- Uses round-robin fairness on contention.
- A watchdog terminates cycles the slave never answers.

Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- SEL_W, 4, byte-select width
- TIMEOUT, 255, cycles with stb high and no ack/err/rty before forced error; 0 disables the watchdog

Ports:
- clk_bus  in  1  bus clock; everything is on the rising edge
- rst_bus  in  1  asynchronous, active-low reset
- m0_adr_i, m1_adr_i  in  ADDR_W  master address
- m0_dat_i, m1_dat_i  in  DATA_W  master write data
- m0_sel_i, m1_sel_i  in  SEL_W  master byte selects
- m0_we_i, m1_we_i  in  1  write enable
- m0_cyc_i, m1_cyc_i  in  1  cycle request / bus hold
- m0_stb_i, m1_stb_i  in  1  strobe
- m0_dat_o, m1_dat_o  out  DATA_W  read data (s_dat_i, broadcast)
- m0_ack_o, m1_ack_o  out  1  ack, owner only
- m0_err_o, m1_err_o  out  1  error, owner only (slave err or timeout)
- m0_rty_o, m1_rty_o  out  1  retry, owner only
- s_adr_o  out  ADDR_W  slave address
- s_dat_o  out  DATA_W  slave write data
- s_sel_o  out  SEL_W  slave byte selects
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_dat_i  in  DATA_W  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1  slave responses
- grant_o  out  2  one-hot current owner ({m1,m0}); 00 when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- States:
  - IDLE, GRANT0, GRANT1: registered.
  - last_grant: 1-bit register holding the last owner; reset value 1, so m0 wins first.
- Reset (rst_bus low, asynchronous):
  - state=IDLE, last_grant=1, watchdog counter=0.
  - Immediately and without a clock edge: all s_* outputs 0, all m*_ack/err/rty 0, grant_o=00, timeout_o=0.
  - A cycle aborted by reset is not resumed.
- IDLE:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o are all 0.
  - On the edge: only m0_cyc_i -> GRANT0; only m1_cyc_i -> GRANT1.
  - Both requesting -> grant to the master that is not last_grant; last_grant is updated on entry.
- GRANTn, signal routing:
  - s_adr/dat/sel/we/cyc/stb follow mn_* combinationally.
  - s_ack_i/err_i/rty_i are routed to mn_*_o only; the other master's responses are held at 0.
  - m*_dat_o = s_dat_i for both masters; only ack qualifies the data.
- Latency:
  - Request first seen in IDLE at edge T -> slave sees cyc/stb during cycle T+1.
  - A single-cycle-ack slave acks at T+2.
  - No added latency per transfer while the grant is held.
- Release:
  - mn_cyc_i low while in GRANTn -> IDLE next edge. There is exactly one dead cycle before any re-grant.
  - No preemption: the other master waits however long mn holds cyc.
  - If mn drops cyc in the same cycle as an ack, the ack is still delivered.
- Watchdog (TIMEOUT>0):
  - Counter clears on grant entry and on any s_ack_i/s_err_i/s_rty_i.
  - Counter increments each cycle s_stb_o=1 with no response. Width is ceil(log2(TIMEOUT+1)) and it saturates, never wraps.
  - When the counter reaches TIMEOUT, the next cycle: mn_err_o=1 and timeout_o=1 for one cycle, s_cyc_o/s_stb_o forced 0, state -> IDLE.
  - A slave response arriving in that same cycle is ignored.
- Masters must not assert stb without cyc. stb without cyc is treated as no request.

Test Plan:
- Single write: m0 write adr=0x100 dat=0xDEADBEEF sel=F, slave acks 1 cycle after stb -> s_cyc_o high at T+1, s_we_o=1, s_dat_o=0xDEADBEEF, m0_ack_o pulse at T+2, m1_ack_o=0 throughout, grant_o=01.
- Contention after reset: m0 and m1 raise cyc in the same cycle for single reads -> m0 served first, one dead cycle, then m1. Repeating the contention -> m1 then m0 (alternation holds over 4 rounds).
- Bus hold: m1 keeps cyc across 4 reads (0x0,0x4,0x8,0xC) while m0 requests from the 2nd read -> m0 is granted only one cycle after m1 drops cyc, and m0 sees no ack during m1 ownership.
- Read routing: slave returns 0x12345678 for m1 -> m1_dat_o=0x12345678 with m1_ack_o; m0_ack_o=0.
- Timeout: TIMEOUT=8, slave never responds to m0 stb -> m0_err_o and timeout_o pulse exactly 9 cycles after s_stb_o rises, s_cyc_o=0 that cycle, grant_o=00 next cycle.
- Async reset mid-grant: rst_bus low between clock edges during GRANT1 -> s_cyc_o and grant_o go to 0 immediately. After release with both requesting, m0 wins.
